// File: rtl/spi_pkg.sv
// Shared SPI responder definitions: mode constant, default word width, FSM state type.
package spi_pkg;

   // SPI mode encoding {CPOL, CPHA}; this responder implements mode 0.
   localparam logic [1:0] SPI_MODE0 = 2'b00;

   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for an asynchronous SPI pin, followed by an edge-detect flop.
// rise_c / fall_c are single-cycle pulses derived from the last synchronizer stage.
module spi_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b0
) (
   input  logic clock_in,
   input  logic reset,
   input  logic d_i,
   output logic rise_c,
   output logic fall_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;

   // Synchronizer chain plus one flop holding the previous synced level.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         edge_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_c =  sync_q[SYNC_STAGES-1] & ~edge_q;
   assign fall_c = ~sync_q[SYNC_STAGES-1] &  edge_q;

endmodule : spi_sync

// File: rtl/spi_slave.sv
// SPI responder, mode 0, MSB first, oversampled on clock_in.
// Optional feature: define SPI_SLAVE_OVERRUN_EN to add the sticky overrun_o flag.
module spi_slave
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clock_in,
   input  logic              reset,
   input  logic              sclk_i,
   input  logic              mosi_i,
   input  logic              ssn_i,
   output logic              miso_o,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_load_i,
   output logic              tx_ready_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   input  logic              rx_ack_i,
   output logic              busy_o
`ifdef SPI_SLAVE_OVERRUN_EN
   ,output logic             overrun_o
`endif
);

   localparam int unsigned CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic        CPOL    = SPI_MODE0[1];
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic sclk_rise_c, sclk_fall_c, ssn_rise_c, ssn_fall_c;
   logic sample_c, drive_c, bit_c, done_c, start_c, abort_c, mosi_bit_c;

   logic [SYNC_STAGES-1:0] mosi_sync_q;
   spi_state_e             state_q, state_d;
   logic [DATA_W-1:0]      shift_q, shift_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]      tx_buf_q, tx_buf_d;
   logic                   tx_ready_q, tx_ready_d;
   logic [DATA_W-1:0]      rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   miso_q, miso_d;
   logic                   start_q;
   logic                   busy_q;

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clock_in (clock_in),
      .reset    (reset),
      .d_i      (sclk_i),
      .rise_c   (sclk_rise_c),
      .fall_c   (sclk_fall_c)
   );

   // ssn idles high, so its synchronizer resets high to avoid a spurious select edge.
   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssn (
      .clock_in (clock_in),
      .reset    (reset),
      .d_i      (ssn_i),
      .rise_c   (ssn_rise_c),
      .fall_c   (ssn_fall_c)
   );

   // mosi needs only a level synchronizer, same depth as the sclk path.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) mosi_sync_q <= '0;
      else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
   end

   assign mosi_bit_c = mosi_sync_q[SYNC_STAGES-1];
   assign sample_c   = CPOL ? sclk_fall_c : sclk_rise_c;
   assign drive_c    = CPOL ? sclk_rise_c : sclk_fall_c;
   // Deselect wins over a simultaneous sample edge.
   assign abort_c    = (state_q == SHIFT) && ssn_rise_c;
   assign bit_c      = (state_q == SHIFT) && !ssn_rise_c && sample_c;
   assign done_c     = bit_c && (bit_cnt_q == LAST_BIT);
   assign start_c    = ((state_q == IDLE) && ssn_fall_c) || done_c;

   // State register.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic: frame follows the synced select line.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ssn_fall_c) state_d = SHIFT;
         SHIFT:   if (ssn_rise_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values.
   always_comb begin
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      tx_buf_d   = tx_buf_q;
      tx_ready_d = tx_ready_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      miso_d     = miso_q;

      if (rx_ack_i) rx_valid_d = 1'b0;

      if (bit_c) begin
         shift_d   = {shift_q[DATA_W-2:0], mosi_bit_c};
         bit_cnt_d = done_c ? '0 : bit_cnt_q + CNT_W'(1);
      end

      if (done_c) begin
         rx_data_d  = {shift_q[DATA_W-2:0], mosi_bit_c};
         rx_valid_d = 1'b1;
      end

      // Word start: an empty buffer sends zeros; the buffer is released either way.
      if (start_c) begin
         shift_d    = tx_ready_q ? '0 : tx_buf_q;
         tx_ready_d = 1'b1;
      end

      // A load into an empty buffer is held for the next word start.
      if (tx_load_i && tx_ready_q) begin
         tx_buf_d   = tx_data_i;
         tx_ready_d = 1'b0;
      end

      // No drive edge follows the final bit with a changed MSB, so skip when bit_cnt wrapped.
      if (start_q)
         miso_d = shift_q[DATA_W-1];
      else if (drive_c && (state_q == SHIFT) && (bit_cnt_q != '0))
         miso_d = shift_q[DATA_W-1];

      if (abort_c) begin
         bit_cnt_d = '0;
         miso_d    = 1'b0;
      end
      if (state_q == IDLE) miso_d = 1'b0;
   end

   // Datapath registers.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         tx_buf_q   <= '0;
         tx_ready_q <= 1'b1;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         miso_q     <= 1'b0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_buf_q   <= tx_buf_d;
         tx_ready_q <= tx_ready_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         miso_q     <= miso_d;
         start_q    <= start_c && !abort_c;
         busy_q     <= (state_d == SHIFT);
      end
   end

   assign miso_o     = miso_q;
   assign tx_ready_o = tx_ready_q;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign busy_o     = busy_q;

`ifdef SPI_SLAVE_OVERRUN_EN
   logic overrun_q, overrun_d;

   // Sticky overrun: a word lands on unread data with no ack that cycle.
   always_comb begin
      overrun_d = overrun_q;
      if (rx_ack_i)                    overrun_d = 1'b0;
      if (done_c && rx_valid_q && !rx_ack_i) overrun_d = 1'b1;
   end

   // Overrun register.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) overrun_q <= 1'b0;
      else       overrun_q <= overrun_d;
   end

   assign overrun_o = overrun_q;
`endif

endmodule : spi_slave

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed scenarios plus randomized frames against a word-level model.
module tb_spi_slave;

   localparam int unsigned HP = 8;

   logic       clock_in = 1'b0;
   logic       reset    = 1'b1;
   logic       sclk     = 1'b0;
   logic       mosi     = 1'b0;
   logic       ssn      = 1'b1;
   logic       miso;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_load  = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack   = 1'b0;
   logic       busy;
`ifdef SPI_SLAVE_OVERRUN_EN
   logic       overrun;
`endif

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   // Word-level reference model of the host-visible state.
   logic [7:0] m_tx_buf;
   bit         m_tx_full;
   logic [7:0] m_cur_tx;
   logic [7:0] m_rx_data;
   bit         m_rx_valid;
   bit         m_ovr;

   spi_slave dut (
      .clock_in   (clock_in),
      .reset      (reset),
      .sclk_i     (sclk),
      .mosi_i     (mosi),
      .ssn_i      (ssn),
      .miso_o     (miso),
      .tx_data_i  (tx_data),
      .tx_load_i  (tx_load),
      .tx_ready_o (tx_ready),
      .rx_data_o  (rx_data),
      .rx_valid_o (rx_valid),
      .rx_ack_i   (rx_ack),
      .busy_o     (busy)
`ifdef SPI_SLAVE_OVERRUN_EN
      ,.overrun_o (overrun)
`endif
   );

   always #5 clock_in = ~clock_in;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock_in);
   endtask

   task automatic model_reset();
      m_tx_buf   = 8'h00;
      m_tx_full  = 1'b0;
      m_cur_tx   = 8'h00;
      m_rx_data  = 8'h00;
      m_rx_valid = 1'b0;
      m_ovr      = 1'b0;
   endtask

   // A word begins: it carries the buffered byte if one is pending, else zero.
   task automatic model_word_start();
      m_cur_tx  = m_tx_full ? m_tx_buf : 8'h00;
      m_tx_full = 1'b0;
   endtask

   task automatic check_host(input string tag);
      check_eq({tag, ".tx_ready"}, tx_ready, !m_tx_full);
      check_eq({tag, ".rx_valid"}, rx_valid, m_rx_valid);
      check_eq({tag, ".rx_data"},  rx_data,  m_rx_data);
`ifdef SPI_SLAVE_OVERRUN_EN
      check_eq({tag, ".overrun"},  overrun,  m_ovr);
`endif
   endtask

   task automatic host_load(input logic [7:0] d);
      check_eq("load.tx_ready", tx_ready, !m_tx_full);
      tx_data = d;
      tx_load = 1'b1;
      cyc(1);
      tx_load = 1'b0;
      if (!m_tx_full) begin
         m_tx_buf  = d;
         m_tx_full = 1'b1;
      end
      cyc(1);
   endtask

   task automatic host_ack();
      rx_ack = 1'b1;
      cyc(1);
      rx_ack = 1'b0;
      m_rx_valid = 1'b0;
      m_ovr      = 1'b0;
      cyc(1);
   endtask

   task automatic frame_begin();
      ssn = 1'b0;
      model_word_start();
      cyc(10);
      check_eq("begin.busy", busy, 1'b1);
      check_eq("begin.tx_ready", tx_ready, 1'b1);
   endtask

   task automatic frame_end(input string tag);
      ssn = 1'b1;
      cyc(10);
      check_eq({tag, ".busy"}, busy, 1'b0);
      check_eq({tag, ".miso"}, miso, 1'b0);
      check_host(tag);
   endtask

   // Clock out nbits bits MSB first; miso is sampled just before each rising edge.
   task automatic spi_bits(input logic [7:0] w, input int nbits, output logic [7:0] got);
      got = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = w[i];
         cyc(HP);
         got[i] = miso;
         sclk = 1'b1;
         cyc(HP);
         sclk = 1'b0;
      end
   endtask

   task automatic spi_word(input string tag, input logic [7:0] w);
      logic [7:0] got;
      logic [7:0] exp_miso;
      exp_miso = m_cur_tx;
      spi_bits(w, 8, got);
      if (m_rx_valid) m_ovr = 1'b1;
      m_rx_data  = w;
      m_rx_valid = 1'b1;
      model_word_start();
      check_eq({tag, ".miso_word"}, got, exp_miso);
      check_host(tag);
   endtask

   initial begin
      logic [7:0] dummy;
      model_reset();
      cyc(3);
      check_eq("rst.miso", miso, 1'b0);
      check_eq("rst.busy", busy, 1'b0);
      check_host("rst");
      reset = 1'b0;
      cyc(3);

      // Loaded byte goes out while a byte comes in.
      host_load(8'hA5);
      frame_begin();
      spi_word("a5_3c", 8'h3C);
      frame_end("a5_3c.end");
      host_ack();

      // Two words in one frame, only the first preloaded.
      host_load(8'hF0);
      frame_begin();
      spi_word("f0.w0", 8'h12);
      host_ack();
      spi_word("f0.w1", 8'h34);
      frame_end("f0.end");
      host_ack();

      // Deselect after 5 bits discards the partial word.
      frame_begin();
      spi_bits(8'hFF, 5, dummy);
      frame_end("abort");
      frame_begin();
      spi_word("after_abort", 8'h81);
      frame_end("after_abort.end");
      host_ack();

      // Two unacknowledged words: second overwrites, overrun flags it.
      frame_begin();
      spi_word("ovr.w0", 8'h11);
      spi_word("ovr.w1", 8'h22);
      frame_end("ovr.end");
      host_ack();
      check_host("ovr.ack");

      // Reset in the middle of a frame, then a clean frame.
      host_load(8'h77);
      frame_begin();
      spi_bits(8'hC3, 3, dummy);
      reset = 1'b1;
      cyc(2);
      model_reset();
      check_eq("midrst.miso", miso, 1'b0);
      check_eq("midrst.busy", busy, 1'b0);
      check_host("midrst");
      ssn = 1'b1;
      reset = 1'b0;
      cyc(10);
      frame_begin();
      spi_word("post_rst", 8'h5A);
      frame_end("post_rst.end");
      host_ack();

      // Randomized frames: optional preload, 1-3 words, random acks.
      for (int f = 0; f < 20; f++) begin
         if ($urandom_range(1, 0) == 1) host_load(8'($urandom));
         frame_begin();
         for (int k = 0; k < int'($urandom_range(3, 1)); k++) begin
            spi_word("rand", 8'($urandom));
            if ($urandom_range(1, 0) == 1) host_ack();
         end
         frame_end("rand.end");
         if ($urandom_range(1, 0) == 1) host_ack();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_spi_slave
